// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: freeze/flush/bubble arbitration, debug halt, memory timeout.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             dbg_halt_i,
    output logic             freeze_if_o,
    output logic             flush_if_o,
    output logic             freeze_id_o,
    output logic             flush_id_o,
    output logic             freeze_ex_o,
    output logic             freeze_mem_o,
    output logic             bubble_wb_o,
    output logic             halted_o,
    output logic             mem_error_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2,
        ERR      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_stall;

    assign mem_stall = mem_req_i & ~mem_ready_i;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (dbg_halt_i) begin
                    state_d = HALT;
                end
            end
            MEM_WAIT: begin
                // wait_cnt holds stalled cycles already spent; this cycle is stall number wait_cnt+1.
                if (mem_ready_i) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            HALT: begin
                if (!dbg_halt_i) begin
                    state_d = RUN;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Mealy outputs, forced low while reset is asserted.
    always_comb begin
        freeze_if_o  = 1'b0;
        flush_if_o   = 1'b0;
        freeze_id_o  = 1'b0;
        flush_id_o   = 1'b0;
        freeze_ex_o  = 1'b0;
        freeze_mem_o = 1'b0;
        bubble_wb_o  = 1'b0;
        halted_o     = 1'b0;
        mem_error_o  = 1'b0;
        if (!rst) begin
            if (state_q == ERR || state_q == HALT) begin
                freeze_if_o  = 1'b1;
                freeze_id_o  = 1'b1;
                freeze_ex_o  = 1'b1;
                freeze_mem_o = 1'b1;
                bubble_wb_o  = 1'b1;
                halted_o     = (state_q == HALT);
                mem_error_o  = (state_q == ERR);
            end else if (mem_stall) begin
                freeze_if_o  = 1'b1;
                freeze_id_o  = 1'b1;
                freeze_ex_o  = 1'b1;
                freeze_mem_o = 1'b1;
                bubble_wb_o  = 1'b1;
            end else if (branch_taken_i) begin
                // A hazard alongside a taken branch belongs to a wrong-path instruction.
                flush_if_o = 1'b1;
                flush_id_o = 1'b1;
            end else if (hazard_i) begin
                freeze_if_o = 1'b1;
                flush_id_o  = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc;

    assign stall_inc = freeze_if_o & (state_q == RUN || state_q == MEM_WAIT);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_if_o && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
